// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the multiplexed 7-segment parity display.
// Segment bit i drives S(i+1); S1..S7 correspond to the classic a..g layout.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_OK    = 2'd1,
        ST_PERR  = 2'd2,
        ST_RERR  = 2'd3
    } dstat_e;

    // Displayable codes never exceed 19, so five bits of value are always enough.
    localparam int VAL_W = 5;

    typedef struct packed {
        dstat_e           st;
        logic [VAL_W-1:0] val;
    } digit_t;

    localparam logic [9:0][6:0] GLYPH_ROM = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] GLYPH_PERR  = 7'h40;
    localparam logic [6:0] GLYPH_RERR  = 7'h49;
    localparam digit_t     DIGIT_BLANK = '{st: ST_BLANK, val: '0};

endpackage

// File: rtl/seg7_scan_parity_if.sv
// Digit write port plus error-clear control; the writer holds the master side.
interface seg7_scan_parity_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 5
);
    logic                          wr_valid;
    logic [$clog2(NUM_DIGITS)-1:0] wr_sel;
    logic [DATA_W-1:0]             wr_data;
    logic                          wr_parity;
    logic                          err_clr;

    modport master (output wr_valid, wr_sel, wr_data, wr_parity, err_clr);
    modport slave  (input  wr_valid, wr_sel, wr_data, wr_parity, err_clr);
endinterface

// File: rtl/seg7_glyph.sv
// Combinational map from a stored digit entry to its segment pattern and decimal point.
module seg7_glyph
    import seg7_pkg::*;
(
    input  digit_t     d,
    output logic [6:0] seg,
    output logic       dp
);
    logic             hi;
    logic [VAL_W-1:0] v;

    always_comb begin
        hi  = (d.val >= VAL_W'(10));
        v   = hi ? (d.val - VAL_W'(10)) : d.val;
        seg = '0;
        dp  = 1'b0;
        case (d.st)
            // Codes 10..19 reuse the 0..9 glyph and flag the tens with dp.
            ST_OK: begin
                seg = GLYPH_ROM[v[3:0]];
                dp  = hi;
            end
            ST_PERR: seg = GLYPH_PERR;
            ST_RERR: seg = GLYPH_RERR;
            default: seg = '0;
        endcase
    end
endmodule

// File: rtl/seg7_scan_parity.sv
// Time-multiplexed 7-segment driver with parity-checked digit writes and an error counter.
// Output path: digit select register, then glyph register, giving two-edge write-to-display latency.
module seg7_scan_parity
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 5,
    parameter int MAX_VAL    = 19,
    parameter int SCAN_DIV   = 1000,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_scan_parity_if.slave     wr,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  err_sticky,
    output logic [CNT_W-1:0]      err_cnt
);
    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam int PW    = $clog2(SCAN_DIV);

    logic [PW-1:0]                presc;
    logic [SEL_W-1:0]             ptr;
    digit_t [NUM_DIGITS-1:0]      digits;
    digit_t                       sel_q;
    digit_t                       wr_ent;
    logic                         wr_ok;
    logic                         perr;
    logic                         rerr;
    logic [6:0]                   g_seg;
    logic                         g_dp;

    always_comb begin
        wr_ok  = wr.wr_valid && ({1'b0, wr.wr_sel} < (SEL_W+1)'(NUM_DIGITS));
        perr   = ^{wr.wr_data, wr.wr_parity};
        rerr   = (wr.wr_data > DATA_W'(MAX_VAL));
        wr_ent = '{st: ST_OK, val: VAL_W'(wr.wr_data)};
        if (perr)
            wr_ent = '{st: ST_PERR, val: '0};
        else if (rerr)
            wr_ent = '{st: ST_RERR, val: '0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= DIGIT_BLANK;
        end else if (wr_ok) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                if (wr.wr_sel == SEL_W'(i)) digits[i] <= wr_ent;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            ptr   <= '0;
        end else if (presc == PW'(SCAN_DIV-1)) begin
            presc <= '0;
            ptr   <= (ptr == SEL_W'(NUM_DIGITS-1)) ? '0 : ptr + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // sel_q lags the pointer by one edge; the mismatch at a pointer step always
    // lands on the blanking cycle, so no stale glyph is ever shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sel_q <= DIGIT_BLANK;
        else     sel_q <= digits[ptr];
    end

    seg7_glyph u_glyph (
        .d   (sel_q),
        .seg (g_seg),
        .dp  (g_dp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '0;
            seg <= '0;
            dp  <= 1'b0;
        end else if (presc == '0) begin
            an  <= '0;
            seg <= '0;
            dp  <= 1'b0;
        end else begin
            an  <= NUM_DIGITS'(1) << ptr;
            seg <= g_seg;
            dp  <= g_dp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (wr.err_clr) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (wr_ok && perr) begin
            err_sticky <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_seg7_scan_parity.sv
// Directed bench for seg7_scan_parity (4 digits, scan divider 4) with a per-cycle reference model.
module tb_seg7_scan_parity;
    localparam int ND  = 4;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        err_sticky;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    seg7_scan_parity_if #(.NUM_DIGITS(ND), .DATA_W(5)) bus ();

    seg7_scan_parity #(
        .NUM_DIGITS(ND), .DATA_W(5), .MAX_VAL(19), .SCAN_DIV(DIV), .CNT_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (bus),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference glyph: st 0=blank 1=ok 2=parity error 3=range error; returns {dp, seg}.
    function automatic logic [7:0] glyph(input int st, input int v);
        logic [6:0] d;
        case (v % 10)
            0: d = 7'b0111111;
            1: d = 7'b0000110;
            2: d = 7'b1011011;
            3: d = 7'b1001111;
            4: d = 7'b1100110;
            5: d = 7'b1101101;
            6: d = 7'b1111101;
            7: d = 7'b0000111;
            8: d = 7'b1111111;
            default: d = 7'b1101111;
        endcase
        case (st)
            1: return {(v >= 10) ? 1'b1 : 1'b0, d};
            2: return {1'b0, 7'b1000000};
            3: return {1'b0, 7'b1001001};
            default: return 8'h00;
        endcase
    endfunction

    // Model: digit contents after the current edge and one/two edges earlier.
    int st_now[ND], vl_now[ND], st_d1[ND], vl_d1[ND], st_d2[ND], vl_d2[ND];
    int k;
    int m_cnt;
    bit m_sticky;

    always @(posedge clk) begin
        int p, pr, pt, dv;
        bit pe;
        logic [3:0] e_an;
        logic [7:0] e_g;
        if (rst) begin
            k = 0; m_cnt = 0; m_sticky = 0;
            for (int i = 0; i < ND; i++) begin
                st_now[i] = 0; vl_now[i] = 0; st_d1[i] = 0;
                vl_d1[i] = 0; st_d2[i] = 0; vl_d2[i] = 0;
            end
        end else begin
            k++;
            st_d2 = st_d1; vl_d2 = vl_d1;
            st_d1 = st_now; vl_d1 = vl_now;
            pe = ^{bus.wr_data, bus.wr_parity};
            dv = int'(bus.wr_data);
            if (bus.wr_valid) begin
                if (pe) begin
                    st_now[bus.wr_sel] = 2; vl_now[bus.wr_sel] = 0;
                end else if (dv > 19) begin
                    st_now[bus.wr_sel] = 3; vl_now[bus.wr_sel] = 0;
                end else begin
                    st_now[bus.wr_sel] = 1; vl_now[bus.wr_sel] = dv;
                end
            end
            if (bus.err_clr) begin
                m_cnt = 0; m_sticky = 0;
            end else if (bus.wr_valid && pe) begin
                m_sticky = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        #1;
        e_an = '0;
        e_g  = '0;
        if (!rst) begin
            p  = k - 1;
            pr = p % DIV;
            pt = (p / DIV) % ND;
            if (pr != 0) begin
                e_an = 4'(1 << pt);
                e_g  = glyph(st_d2[pt], vl_d2[pt]);
            end
        end
        check("model_an", an, e_an);
        check("model_seg", seg, e_g[6:0]);
        check("model_dp", dp, e_g[7]);
        check("model_sticky", err_sticky, m_sticky);
        check("model_cnt", err_cnt, m_cnt);
    end

    task automatic wr(input int sel, input int data, input bit par, input bit clr);
        bus.wr_valid  = 1'b1;
        bus.wr_sel    = 2'(sel);
        bus.wr_data   = 5'(data);
        bus.wr_parity = par;
        bus.err_clr   = clr;
        @(negedge clk);
        bus.wr_valid  = 1'b0;
        bus.err_clr   = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] want);
        int n;
        n = 0;
        while (an !== want && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (an !== want) begin
            checks++;
            errors++;
            $display("FAIL wait_an: timed out, an=%b wanted %b", an, want);
        end
    endtask

    // A blank cycle first guarantees the slot reflects any write already issued.
    task automatic wait_slot(input int d);
        wait_an(4'b0000);
        wait_an(4'(1 << d));
    endtask

    logic [3:0] seq [6];

    initial begin
        bus.wr_valid = 1'b0; bus.wr_sel = '0; bus.wr_data = '0;
        bus.wr_parity = 1'b0; bus.err_clr = 1'b0;
        seq = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};

        repeat (3) @(negedge clk);
        check("rst_an", an, 4'b0);
        check("rst_seg", seg, 7'b0);
        check("rst_cnt", err_cnt, 8'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("scan_seq_an", an, seq[i]);
            check("scan_seq_seg", seg, 7'b0);
        end

        wr(1, 7, 1'b1, 1'b0);
        wait_slot(1);
        check("d1_seg7", seg, 7'b0000111);
        check("d1_dp", dp, 1'b0);
        check("d1_cnt", err_cnt, 8'd0);

        wr(2, 13, 1'b1, 1'b0);
        wait_slot(2);
        check("d2_seg3", seg, 7'b1001111);
        check("d2_dp", dp, 1'b1);

        wr(0, 3, 1'b1, 1'b0);
        check("perr_sticky", err_sticky, 1'b1);
        check("perr_cnt", err_cnt, 8'd1);
        wait_slot(0);
        check("d0_perr_seg", seg, 7'b1000000);

        wr(3, 21, 1'b1, 1'b0);
        wait_slot(3);
        check("d3_rerr_seg", seg, 7'b1001001);
        check("d3_cnt_same", err_cnt, 8'd1);

        bus.wr_valid = 1'b1; bus.wr_sel = 2'd0; bus.wr_data = 5'd3; bus.wr_parity = 1'b1;
        repeat (300) @(negedge clk);
        bus.wr_valid = 1'b0;
        check("cnt_saturate", err_cnt, 8'd255);

        wr(2, 3, 1'b1, 1'b1);
        check("clr_cnt", err_cnt, 8'd0);
        check("clr_sticky", err_sticky, 1'b0);
        wait_slot(2);
        check("clr_d2_perr", seg, 7'b1000000);

        wr(3, 3, 1'b1, 1'b0);
        check("post_clr_cnt", err_cnt, 8'd1);
        wait_slot(2);
        #1 rst = 1'b1;
        #1;
        check("async_an", an, 4'b0);
        check("async_seg", seg, 7'b0);
        check("async_cnt", err_cnt, 8'd0);
        check("async_sticky", err_sticky, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg7_scan_parity.md
SEG7_SCAN_PARITY -- requirements
Module: seg7_scan_parity

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of time-multiplexed digits (2..8).
REQ-002 Parameter DATA_W, default 5, width of each digit code.
REQ-003 Parameter MAX_VAL, default 19, largest displayable code; MAX_VAL SHALL be at most 19.
REQ-004 Parameter SCAN_DIV, default 1000, clock cycles each digit is driven (>= 2).
REQ-005 Parameter CNT_W, default 8, width of the parity error counter.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst  input  1  asynchronous reset, active-high.
REQ-008 wr_valid  input  1  write request for one digit.
REQ-009 wr_sel  input  clog2(NUM_DIGITS)  target digit index.
REQ-010 wr_data  input  DATA_W  digit code.
REQ-011 wr_parity  input  1  even-parity bit over wr_data.
REQ-012 err_clr  input  1  clears error counter and sticky flag.
REQ-013 an  output  NUM_DIGITS  one-hot digit enable, active-high.
REQ-014 seg  output  7  segments, seg[0]=S1 .. seg[6]=S7, active-high.
REQ-015 dp  output  1  decimal point, active-high.
REQ-016 err_sticky  output  1  set by any parity error since last clear.
REQ-017 err_cnt  output  CNT_W  saturating count of parity-error writes.

Function
REQ-018 Write accepted on every clk edge with wr_valid=1 and wr_sel < NUM_DIGITS; wr_sel >= NUM_DIGITS write ignored, no state change.
REQ-019 Parity error when XOR of wr_data and wr_parity is 1; digit stored with status PERR.
REQ-020 Good parity and wr_data > MAX_VAL: digit stored with status RERR.
REQ-021 Good parity and wr_data <= MAX_VAL: digit stored with status OK and value.
REQ-022 OK glyph: values 0-9 standard decimal glyph, dp=0; values 10-19 glyph of (value-10), dp=1.
REQ-023 PERR glyph: only seg[6] (S7) lit, dp=0.
REQ-024 RERR glyph: seg[0], seg[3], seg[6] lit, dp=0.
REQ-025 BLANK glyph (post-reset status): all segments and dp off.
REQ-026 Scan: prescaler counts 0..SCAN_DIV-1; at SCAN_DIV-1 prescaler wraps to 0 and digit pointer advances, NUM_DIGITS-1 wraps to 0.
REQ-027 Prescaler value 0 is a blanking cycle: an, seg, dp all 0; values 1..SCAN_DIV-1 drive an[pointer]=1 and that digit's glyph.
REQ-028 an, seg, dp registered; a write to the currently driven digit at edge t appears on seg/dp at edge t+2.
REQ-029 Each parity-error write sets err_sticky and increments err_cnt by 1, saturating at all-ones.
REQ-030 err_clr has priority over a same-cycle parity error: err_cnt=0, err_sticky=0 next edge; digit still stored as PERR.
REQ-031 Same-cycle write to the digit being driven: glyph switches per REQ-028 without disturbing scan timing.

Reset
REQ-032 While rst=1: an=0, seg=0, dp=0, err_sticky=0, err_cnt=0, prescaler=0, pointer=0, all digits BLANK.
REQ-033 rst asserted mid-scan or mid-write aborts immediately; write in that cycle discarded.
REQ-034 After rst release, first non-blank digit output is digit 0 at second edge.

Structure
REQ-035 Shared package seg7_pkg holds digit status enum (BLANK, OK, PERR, RERR), 10-entry glyph ROM constant, PERR/RERR glyph constants.
REQ-036 One sub-module seg7_glyph: combinational status+value to seg/dp mapping.
REQ-037 Storage: NUM_DIGITS entries of {status, value}; no memories inferred.

Verification (NUM_DIGITS=4, SCAN_DIV=4)
REQ-038 Reset then idle -> an sequence 0,0001,0001,0001,0,0010,... with seg=0, dp=0 throughout.
REQ-039 Write digit1 data=5'd7 parity=1 -> during digit 1 slot seg=0000111, dp=0; err_cnt=0.
REQ-040 Write digit2 data=5'd13 parity=1 -> digit 2 shows glyph 3 (seg=1001111), dp=1.
REQ-041 Write digit0 data=5'd3 parity=1 -> digit 0 seg=1000000, err_sticky=1, err_cnt=1; 300 such writes -> err_cnt=255.
REQ-042 Write digit3 data=5'd21 parity=1 -> digit 3 seg=1001001; err_cnt unchanged.
REQ-043 Parity-error write with err_clr same cycle -> err_cnt=0, err_sticky=0, digit shows PERR; rst mid-scan -> all outputs 0 asynchronously.
